// File: rtl/stall_mem_responder.sv
// -----------------------------------------------------------------------------
// stall_mem_responder
//   Responder side of the stalling-memory handshake. A direct-mapped,
//   single-word-line, write-through, no-write-allocate cache sits in front of
//   an internal backing word memory with a fixed miss latency.
//
//   Read hits complete combinationally in the request cycle. Read misses and
//   all writes stall for MISS_LATENCY cycles and then complete with Done. On
//   completion, a read miss fills the line. A write updates the backing memory
//   and also updates the line data if the write address is cached.
//
// Parameters
//   MISS_LATENCY : cycles from request to Done for slow accesses (2..15)
//   LINES        : number of cache lines, power of two (2..64)
//   MEM_WORDS    : backing-memory depth in 16-bit words, power of two
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   Addr       in   byte address (must be word aligned)
//   DataIn     in   write data
//   Rd         in   read request
//   Wr         in   write request
//   createdump in   reserved, ignored
//   DataOut    out  read data, valid with Done on reads, 0 otherwise
//   Done       out  access completes this cycle
//   Stall      out  access in progress, initiator holds its inputs
//   CacheHit   out  read hit, asserted together with Done
//   err        out  illegal request (Rd&Wr, or misaligned address)
// -----------------------------------------------------------------------------
module stall_mem_responder #(
    parameter int unsigned MISS_LATENCY = 4,
    parameter int unsigned LINES        = 8,
    parameter int unsigned MEM_WORDS    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    input  logic        createdump,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 15 - IDX_W;
    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(MISS_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    // Latched request
    logic [14:0] req_wa_q;
    logic [15:0] req_wdata_q;
    logic        req_wr_q;
    logic [15:0] rdata_q;

    // Cache and backing storage
    logic [LINES-1:0] line_valid_q;
    logic [TAG_W-1:0] line_tag_q  [LINES];
    logic [15:0]      line_data_q [LINES];
    logic [15:0]      mem_q       [MEM_WORDS];

    // Incoming request decode
    logic [14:0]       wa_in;
    logic [IDX_W-1:0]  idx_in;
    logic [TAG_W-1:0]  tag_in;
    logic              req_illegal;
    logic              req_hit;
    logic              req_slow;

    assign wa_in  = Addr[15:1];
    assign idx_in = wa_in[IDX_W-1:0];
    assign tag_in = wa_in[14:IDX_W];

    assign req_illegal = (Rd && Wr) || ((Rd || Wr) && Addr[0]);
    assign req_hit     = Rd && !req_illegal && line_valid_q[idx_in]
                         && (line_tag_q[idx_in] == tag_in);
    assign req_slow    = (Rd || Wr) && !req_illegal && !req_hit;

    // Latched request decode
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [MEM_AW-1:0] req_maddr;
    logic              req_line_hit;
    logic              commit;

    assign req_idx      = req_wa_q[IDX_W-1:0];
    assign req_tag      = req_wa_q[14:IDX_W];
    assign req_maddr    = req_wa_q[MEM_AW-1:0];
    assign req_line_hit = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
    // The fill or write takes effect on the edge that moves BUSY to DONE.
    assign commit       = (state_q == S_BUSY) && (cnt_q == 4'd1);

    logic unused_createdump;
    assign unused_createdump = createdump;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_slow) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic; everything is forced low while reset is asserted
    always_comb begin
        DataOut  = '0;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (req_illegal) begin
                        err = 1'b1;
                    end else if (req_hit) begin
                        Done     = 1'b1;
                        CacheHit = 1'b1;
                        DataOut  = line_data_q[idx_in];
                    end else if (req_slow) begin
                        Stall = 1'b1;
                    end
                end
                S_BUSY: begin
                    Stall = 1'b1;
                end
                S_DONE: begin
                    Done    = 1'b1;
                    DataOut = req_wr_q ? 16'h0000 : rdata_q;
                end
                default: begin
                    DataOut = '0;
                end
            endcase
        end
    end

    // Request latch and read-return register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_wa_q    <= '0;
            req_wdata_q <= '0;
            req_wr_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (state_q == S_IDLE && req_slow) begin
                req_wa_q    <= wa_in;
                req_wdata_q <= DataIn;
                req_wr_q    <= Wr;
            end
            if (commit && !req_wr_q) begin
                rdata_q <= mem_q[req_maddr];
            end
        end
    end

    // Valid bits are the only cache state cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (commit && !req_wr_q) begin
            line_valid_q[req_idx] <= 1'b1;
        end
    end

    // Tag/data arrays and backing memory are not reset. A reset during BUSY
    // returns the FSM to IDLE, so commit never fires and nothing is written.
    always_ff @(posedge clk) begin
        if (commit) begin
            if (req_wr_q) begin
                mem_q[req_maddr] <= req_wdata_q;
                if (req_line_hit) begin
                    line_data_q[req_idx] <= req_wdata_q;
                end
            end else begin
                line_tag_q[req_idx]  <= req_tag;
                line_data_q[req_idx] <= mem_q[req_maddr];
            end
        end
    end

endmodule

// File: tb/tb_stall_mem_responder.sv
module tb_stall_mem_responder;

    localparam int unsigned LAT = 4;
    localparam int unsigned NL  = 8;
    localparam int unsigned MW  = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn, DataOut;
    logic        Rd, Wr, createdump;
    logic        Done, Stall, CacheHit, err;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays indexed by arithmetic on the word address
    logic [15:0] m_mem  [MW];
    bit          m_valid[NL];
    int unsigned m_tag  [NL];
    logic [15:0] m_data [NL];

    stall_mem_responder #(
        .MISS_LATENCY(LAT),
        .LINES       (NL),
        .MEM_WORDS   (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .Rd        (Rd),
        .Wr        (Wr),
        .createdump(createdump),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit e_err, input bit e_stall,
                              input bit e_done, input bit e_hit, input logic [15:0] e_dout);
        check_eq({tag, ".err"},      {15'b0, err},      {15'b0, e_err});
        check_eq({tag, ".Stall"},    {15'b0, Stall},    {15'b0, e_stall});
        check_eq({tag, ".Done"},     {15'b0, Done},     {15'b0, e_done});
        check_eq({tag, ".CacheHit"}, {15'b0, CacheHit}, {15'b0, e_hit});
        check_eq({tag, ".DataOut"},  DataOut,           e_dout);
    endtask

    task automatic scramble_inputs();
        Addr   = 16'($urandom);
        DataIn = 16'($urandom);
        Rd     = 1'($urandom);
        Wr     = 1'($urandom);
    endtask

    // Called just after a rising edge; returns just after the next rising edge
    // following completion, so back-to-back hits complete one per cycle.
    task automatic access(input string name, input bit rd, input bit wr,
                          input logic [15:0] addr, input logic [15:0] din);
        int unsigned wa, idx, tg, ma;
        logic [15:0] exp_dout;
        wa  = int'(addr[15:1]);
        idx = wa % NL;
        tg  = wa / NL;
        ma  = wa % MW;
        Rd = rd; Wr = wr; Addr = addr; DataIn = din;
        @(negedge clk);
        if ((rd && wr) || ((rd || wr) && addr[0])) begin
            expect_out({name, ".illegal"}, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        end else if (!rd && !wr) begin
            expect_out({name, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        end else if (rd && m_valid[idx] && m_tag[idx] == tg) begin
            expect_out({name, ".hit"}, 1'b0, 1'b0, 1'b1, 1'b1, m_data[idx]);
        end else begin
            expect_out({name, ".stall0"}, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            for (int c = 1; c < int'(LAT); c++) begin
                @(posedge clk); #1;
                scramble_inputs();
                @(negedge clk);
                expect_out({name, ".stall"}, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            end
            @(posedge clk); #1;
            scramble_inputs();
            @(negedge clk);
            exp_dout = rd ? m_mem[ma] : 16'h0000;
            expect_out({name, ".done"}, 1'b0, 1'b0, 1'b1, 1'b0, exp_dout);
            if (wr) begin
                m_mem[ma] = din;
                if (m_valid[idx] && m_tag[idx] == tg) m_data[idx] = din;
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_data[idx]  = m_mem[ma];
            end
        end
        @(posedge clk); #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        int unsigned op, wa;
        logic [15:0] a;
        for (int i = 0; i < int'(MW); i++) m_mem[i] = 16'h0000;
        for (int i = 0; i < int'(NL); i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_data[i] = 16'h0000;
        end
        createdump = 1'b0;
        DataIn = 16'h0000;
        Wr = 1'b0;

        // Outputs held low during reset even with a request present
        rst = 1'b1; Rd = 1'b1; Addr = 16'h0010;
        @(negedge clk);
        expect_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0; Rd = 1'b0;
        @(negedge clk);
        expect_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;

        // Directed sequence
        access("wr10",      1'b0, 1'b1, 16'h0010, 16'hBEEF);
        access("rd10_miss", 1'b1, 1'b0, 16'h0010, 16'h0000);
        access("rd10_hit",  1'b1, 1'b0, 16'h0010, 16'h0000);
        access("wr20",      1'b0, 1'b1, 16'h0020, 16'h1234);
        access("rd20_miss", 1'b1, 1'b0, 16'h0020, 16'h0000);
        access("rd10_miss2",1'b1, 1'b0, 16'h0010, 16'h0000);
        access("rd10_hit2", 1'b1, 1'b0, 16'h0010, 16'h0000);
        access("wr10_upd",  1'b0, 1'b1, 16'h0010, 16'h5555);
        access("rd10_hit3", 1'b1, 1'b0, 16'h0010, 16'h0000);
        access("rd11_odd",  1'b1, 1'b0, 16'h0011, 16'h0000);
        access("rdwr10",    1'b1, 1'b1, 16'h0010, 16'h0000);
        access("rd10_hit4", 1'b1, 1'b0, 16'h0010, 16'h0000);

        // Reset in cycle 2 of a write: the write must be dropped
        Rd = 1'b0; Wr = 1'b1; Addr = 16'h0030; DataIn = 16'h1234;
        @(negedge clk);
        expect_out("rstwr.c0", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        @(negedge clk);
        expect_out("rstwr.c1", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        expect_out("rstwr.async", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        expect_out("rstwr.held", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b0; Wr = 1'b0;
        for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
        @(negedge clk);
        expect_out("rstwr.release", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(posedge clk); #1;
        access("rd30_after_rst", 1'b1, 1'b0, 16'h0030, 16'h0000);
        access("rd10_after_rst", 1'b1, 1'b0, 16'h0010, 16'h0000);

        // Randomized traffic over a small address window plus aliases
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            wa = $urandom_range(0, 47);
            if ($urandom_range(0, 3) == 0) wa = wa + ($urandom_range(1, 3) << 8);
            a = {wa[14:0], 1'b0};
            createdump = 1'($urandom);
            case (op)
                0:       access("rnd", 1'b1, 1'b0, a | 16'h0001, 16'($urandom));
                1:       access("rnd", 1'b1, 1'b1, a, 16'($urandom));
                2:       access("rnd", 1'b0, 1'b0, a, 16'($urandom));
                3, 4, 5, 6: access("rnd", 1'b1, 1'b0, a, 16'($urandom));
                default: access("rnd", 1'b0, 1'b1, a, 16'($urandom));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
